// File: rtl/conv14_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 14x14 convolution scan controller.
// Imported by the handshake interface and the controller.
package conv14_scan_ctrl_pkg;
    localparam int IntSize   = 8;
    localparam int MapDim    = 14;
    localparam int Positions = MapDim * MapDim;
    localparam int PosWidth  = 21;
    localparam int IdxWidth  = 8;
    localparam int MapWidth  = Positions * IntSize;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } state_e;
endpackage

// File: rtl/conv14_scan_ctrl_if.sv
// Downstream result stream: one element plus its map position, valid/ready.
// The controller drives the master side.
interface conv14_scan_ctrl_if;
    import conv14_scan_ctrl_pkg::*;

    logic                out_valid;
    logic                out_ready;
    logic [IntSize-1:0]  out_data;
    logic [IdxWidth-1:0] out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/conv14_scan_ctrl.sv
// Steps the convolver over all 196 positions, streams each result downstream
// and assembles the full result map for the next layer.
module conv14_scan_ctrl
    import conv14_scan_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [PosWidth-1:0] o_pos,
    input  logic [IntSize-1:0]  i_conv_in,
    output logic [MapWidth-1:0] o_map_out,
    conv14_scan_ctrl_if.master  out_if
);

    state_e              r_state;
    state_e              w_next;
    logic [PosWidth-1:0] r_pos;
    logic                r_valid;
    logic [IntSize-1:0]  r_data;
    logic [IdxWidth-1:0] r_idx;
    logic                r_done;
    logic [IntSize-1:0]  r_map [Positions];
    logic                w_adv;
    logic                w_last;

    // Capture is allowed whenever the output slot is empty or being drained.
    assign w_adv  = !r_valid || out_if.out_ready;
    assign w_last = (r_pos == PosWidth'(Positions - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_adv && w_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_if.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < Positions; k++) begin
                r_map[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) r_pos <= '0;
                end
                ST_SCAN: begin
                    if (w_adv) begin
                        r_valid <= 1'b1;
                        r_data  <= i_conv_in;
                        r_idx   <= r_pos[IdxWidth-1:0];
                        r_map[r_pos[IdxWidth-1:0]] <= i_conv_in;
                        if (!w_last) r_pos <= r_pos + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_if.out_ready) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < Positions; k++) begin : g_map
        assign o_map_out[k*IntSize +: IntSize] = r_map[k];
    end

    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = r_done;
    assign o_pos            = r_pos;
    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_idx   = r_idx;

endmodule
